// File: rtl/mips_test_sequencer.sv
// Hardware bring-up sequencer for the pipelined MIPS32 core: program load, register init,
// operand write, supervised run with timeout, and two-word result read-back.
module mips_test_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NREGS  = 32,
  parameter int TMO_W  = 16,
  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_val,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_we,
  output logic [RIDX_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              core_run,
  output logic              core_clr,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              prog_ovf,
  output logic [DATA_W-1:0] result0,
  output logic [DATA_W-1:0] result1,
  output logic [TMO_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_REGS, S_DATA, S_RUN, S_RD0, S_RD1, S_FIN
  } state_t;

  // Counter value whose increment lands on all-ones, i.e. the timeout cycle.
  localparam logic [TMO_W-1:0]  TMO_LAST  = ~TMO_W'(1);
  localparam logic [RIDX_W-1:0] RIDX_LAST = RIDX_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [RIDX_W-1:0] ridx;
  logic              run_first;
  logic [ADDR_W-1:0] data_addr_q;
  logic [DATA_W-1:0] data_val_q;
  logic [ADDR_W-1:0] rd_addr0_q;
  logic [ADDR_W-1:0] rd_addr1_q;

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking here would make ordering inside the block matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      ridx        <= '0;
      run_first   <= 1'b0;
      data_addr_q <= '0;
      data_val_q  <= '0;
      rd_addr0_q  <= '0;
      rd_addr1_q  <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      prog_ovf    <= 1'b0;
      result0     <= '0;
      result1     <= '0;
      run_cycles  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          data_addr_q <= data_addr;
          data_val_q  <= data_val;
          rd_addr0_q  <= rd_addr0;
          rd_addr1_q  <= rd_addr1;
          done        <= 1'b0;
          timeout     <= 1'b0;
          prog_ovf    <= 1'b0;
          result0     <= '0;
          result1     <= '0;
          run_cycles  <= '0;
          ptr         <= '0;
          state       <= S_LOAD;
        end
        S_LOAD: if (ld_valid) begin
          ptr <= ptr + 1'b1;
          if (ld_last) begin
            ridx  <= '0;
            state <= S_REGS;
          end else if (ptr == '1) begin
            // Memory is full and the program has not ended: abandon without wrapping.
            prog_ovf <= 1'b1;
            done     <= 1'b1;
            state    <= S_FIN;
          end
        end
        S_REGS: begin
          ridx <= ridx + 1'b1;
          if (ridx == RIDX_LAST) state <= S_DATA;
        end
        S_DATA: begin
          run_first <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (run_first) begin
            // The clear pulse is still in flight; HALTED may be stale from a previous run.
            run_first <= 1'b0;
          end else begin
            run_cycles <= run_cycles + 1'b1;
            if (core_halted) begin
              state <= S_RD0;
            end else if (run_cycles == TMO_LAST) begin
              timeout <= 1'b1;
              state   <= S_RD0;
            end
          end
        end
        S_RD0: state <= S_RD1;
        S_RD1: begin
          result0 <= mem_rdata;
          done    <= 1'b1;
          state   <= S_FIN;
        end
        S_FIN: begin
          result1 <= mem_rdata;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    core_run  = 1'b0;
    core_clr  = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        mem_addr  = ptr;
        mem_wdata = ld_data;
      end
      S_REGS: begin
        reg_we    = 1'b1;
        reg_addr  = ridx;
        reg_wdata = DATA_W'(ridx);
      end
      S_DATA: begin
        mem_we    = 1'b1;
        mem_addr  = data_addr_q;
        mem_wdata = data_val_q;
      end
      S_RUN: begin
        core_run = 1'b1;
        core_clr = run_first;
      end
      S_RD0: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr0_q;
      end
      S_RD1: begin
        mem_re   = 1'b1;
        mem_addr = rd_addr1_q;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: a behavioural MIPS32 subset core and memory around the
// default instance, plus reduced-width instances for the timeout and overflow corners.
module tb_mips_test_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- main instance (default parameters) ----------------
  logic        start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0, data_val = '0;
  logic [9:0]  data_addr = '0, rd_addr0 = '0, rd_addr1 = '0;
  logic        ld_ready, mem_we, mem_re, reg_we, core_run, core_clr;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, reg_wdata, result0, result1;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  reg_addr;
  logic        core_halted = 1'b0;
  logic        busy, done, timeout, prog_ovf;
  logic [15:0] run_cycles;

  mips_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .data_addr(data_addr), .data_val(data_val), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .core_run(core_run), .core_clr(core_clr), .core_halted(core_halted),
    .busy(busy), .done(done), .timeout(timeout), .prog_ovf(prog_ovf),
    .result0(result0), .result1(result1), .run_cycles(run_cycles)
  );

  // Behavioural core: one instruction per enabled cycle, sharing memory with the sequencer.
  logic [31:0] mem [0:1023];
  logic [31:0] rf  [0:31];
  logic [9:0]  pc = '0;
  wire  [31:0] ir   = mem[pc];
  wire  [5:0]  op   = ir[31:26];
  wire  [4:0]  rs   = ir[25:21];
  wire  [4:0]  rt   = ir[20:16];
  wire  [4:0]  rd   = ir[15:11];
  wire  [31:0] simm = {{16{ir[15]}}, ir[15:0]};
  wire  [31:0] ea   = rf[rs] + simm;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (reg_we) rf[reg_addr] <= reg_wdata;
    if (core_clr) begin
      pc <= '0;
      core_halted <= 1'b0;
    end else if (core_run && !core_halted) begin
      pc <= pc + 10'd1;
      case (op)
        6'h00: rf[rd] <= rf[rs] + rf[rt];
        6'h03: rf[rd] <= rf[rs] | rf[rt];
        6'h05: rf[rd] <= rf[rs] * rf[rt];
        6'h08: rf[rt] <= mem[ea[9:0]];
        6'h09: mem[ea[9:0]] <= rf[rt];
        6'h0a: rf[rt] <= rf[rs] + simm;
        6'h0b: rf[rt] <= rf[rs] - simm;
        6'h0d: if (rf[rs] != 32'd0) pc <= pc + 10'd1 + simm[9:0];
        6'h3f: begin core_halted <= 1'b1; pc <= pc; end
        default: ;
      endcase
    end
  end

  // ---------------- timeout instance (TMO_W=4, never halts) ----------------
  logic        t_start = 1'b0, t_ld_valid = 1'b0, t_ld_last = 1'b0;
  logic [31:0] t_ld_data = '0;
  logic        t_ld_ready, t_mem_we, t_mem_re, t_reg_we, t_core_run, t_core_clr;
  logic [9:0]  t_mem_addr;
  logic [31:0] t_mem_wdata, t_reg_wdata, t_result0, t_result1;
  logic [4:0]  t_reg_addr;
  logic        t_busy, t_done, t_timeout, t_prog_ovf;
  logic [3:0]  t_run_cycles;

  mips_test_sequencer #(.TMO_W(4)) u_tmo (
    .clk(clk), .rst_n(rst_n), .start(t_start),
    .ld_valid(t_ld_valid), .ld_ready(t_ld_ready), .ld_data(t_ld_data), .ld_last(t_ld_last),
    .data_addr(10'd5), .data_val(32'd9), .rd_addr0(10'd1), .rd_addr1(10'd2),
    .mem_we(t_mem_we), .mem_re(t_mem_re), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(32'h1234_5678), .reg_we(t_reg_we), .reg_addr(t_reg_addr),
    .reg_wdata(t_reg_wdata), .core_run(t_core_run), .core_clr(t_core_clr),
    .core_halted(1'b0), .busy(t_busy), .done(t_done), .timeout(t_timeout),
    .prog_ovf(t_prog_ovf), .result0(t_result0), .result1(t_result1),
    .run_cycles(t_run_cycles)
  );

  // ---------------- overflow instance (ADDR_W=3) ----------------
  logic        o_start = 1'b0, o_ld_valid = 1'b0, o_ld_last = 1'b0;
  logic [31:0] o_ld_data = '0;
  logic        o_ld_ready, o_mem_we, o_mem_re, o_reg_we, o_core_run, o_core_clr;
  logic [2:0]  o_mem_addr;
  logic [31:0] o_mem_wdata, o_reg_wdata, o_result0, o_result1;
  logic [4:0]  o_reg_addr;
  logic        o_busy, o_done, o_timeout, o_prog_ovf;
  logic [15:0] o_run_cycles;

  mips_test_sequencer #(.ADDR_W(3)) u_ovf (
    .clk(clk), .rst_n(rst_n), .start(o_start),
    .ld_valid(o_ld_valid), .ld_ready(o_ld_ready), .ld_data(o_ld_data), .ld_last(o_ld_last),
    .data_addr(3'd6), .data_val(32'd3), .rd_addr0(3'd6), .rd_addr1(3'd5),
    .mem_we(o_mem_we), .mem_re(o_mem_re), .mem_addr(o_mem_addr), .mem_wdata(o_mem_wdata),
    .mem_rdata(32'd0), .reg_we(o_reg_we), .reg_addr(o_reg_addr),
    .reg_wdata(o_reg_wdata), .core_run(o_core_run), .core_clr(o_core_clr),
    .core_halted(1'b0), .busy(o_busy), .done(o_done), .timeout(o_timeout),
    .prog_ovf(o_prog_ovf), .result0(o_result0), .result1(o_result1),
    .run_cycles(o_run_cycles)
  );

  // ---------------- factorial program and vector table ----------------
  logic [31:0] prog [0:10] = '{
    32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000, 32'h14431000,
    32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe, 32'hfc000000
  };

  typedef struct {
    string       name;
    bit          toggle;    // ld_valid alternates 1/0 instead of being held
    logic [31:0] dval;      // operand written to address 200
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    int          abort_at;  // >0: pulse reset after this many core_run cycles
    bit          chk_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v);
    int beat = 0, cyc = 1, we_cnt = 0, addr_err = 0, reg_cnt = 0, reg_err = 0;
    int re_cnt = 0, both = 0, clr_cnt = 0, clr_cyc = -1, run_cnt = 0;
    bit fin = 1'b0;
    @(negedge clk);
    data_addr = 10'd200; data_val = v.dval; rd_addr0 = 10'd200; rd_addr1 = 10'd198;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      if (beat < 11) begin
        ld_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
        ld_data  = prog[beat];
        ld_last  = (beat == 10);
      end else begin
        ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
      end
      #1;
      if (ld_valid && ld_ready) beat++;
      if (ld_ready && mem_we) begin
        if (mem_addr != 10'(we_cnt)) addr_err++;
        we_cnt++;
      end
      if (reg_we) begin
        if (reg_addr != 5'(reg_cnt) || reg_wdata != 32'(reg_cnt)) reg_err++;
        reg_cnt++;
      end
      if (mem_re) re_cnt++;
      if (mem_we && mem_re) both++;
      if (core_clr) begin
        clr_cnt++;
        if (clr_cyc < 0) clr_cyc = cyc;
      end
      if (core_run) run_cnt++;
      if (v.abort_at > 0 && run_cnt == v.abort_at) begin
        rst_n = 1'b0;
        #1;
        check({v.name, "_rst_flags"},
              {busy, done, timeout, prog_ovf, core_run, core_clr, mem_we, mem_re, reg_we, ld_ready},
              '0);
        check({v.name, "_rst_cycles"}, run_cycles, 0);
        check({v.name, "_rst_results"}, {result0, result1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({v.name, "_post_rst_quiet"}, {busy, core_run, mem_we, reg_we}, 0);
        return;
      end
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({v.name, "_done_seen"}, fin, 1);
    @(negedge clk);
    #1;
    check({v.name, "_result0"}, result0, v.exp_r0);
    check({v.name, "_result1"}, result1, v.exp_r1);
    check({v.name, "_status"}, {done, timeout, prog_ovf, busy}, 4'b1000);
    check({v.name, "_load_writes"}, we_cnt, 11);
    check({v.name, "_load_addr_order"}, addr_err, 0);
    check({v.name, "_reg_writes"}, reg_cnt, 32);
    check({v.name, "_reg_order"}, reg_err, 0);
    check({v.name, "_reads"}, re_cnt, 2);
    check({v.name, "_we_re_overlap"}, both, 0);
    check({v.name, "_clr_pulses"}, clr_cnt, 1);
    if (v.chk_lat) check({v.name, "_latency"}, clr_cyc, 45);
  endtask

  initial begin
    int beats, we, err, re, cyc;
    bit fin, run_seen, reg_seen;

    vecs[0] = '{"fact7_held",        1'b0, 32'd7, 32'd7, 32'd5040, 0, 1'b1};
    vecs[1] = '{"fact5_toggle",      1'b1, 32'd5, 32'd5, 32'd120,  0, 1'b0};
    vecs[2] = '{"fact1_held",        1'b0, 32'd1, 32'd1, 32'd1,    0, 1'b1};
    vecs[3] = '{"abort_in_run",      1'b0, 32'd6, 32'd0, 32'd0,    5, 1'b0};
    vecs[4] = '{"fact4_after_reset", 1'b1, 32'd4, 32'd4, 32'd24,   0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_flags",
          {busy, done, timeout, prog_ovf, core_run, core_clr, mem_we, mem_re, reg_we, ld_ready}, '0);
    check("reset_data", {result0, result1, run_cycles, mem_addr, mem_wdata}, '0);
    check("reset_tmo_inst", {t_busy, t_done, t_run_cycles, t_core_run}, '0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: single HLT-free beat, core never halts, 4-bit run counter
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    beats = 0; re = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 500) begin
      t_ld_valid = (beats == 0); t_ld_last = 1'b1; t_ld_data = 32'h0e94a000;
      #1;
      if (t_ld_valid && t_ld_ready) beats++;
      if (t_mem_re) re++;
      if (t_done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("tmo_done_seen", fin, 1);
    check("tmo_timeout", t_timeout, 1);
    check("tmo_run_cycles", t_run_cycles, 4'd15);
    check("tmo_reads", re, 2);
    @(negedge clk);
    #1;
    check("tmo_results", {t_result0, t_result1}, {32'h1234_5678, 32'h1234_5678});
    check("tmo_final", {t_done, t_timeout, t_busy}, 3'b110);

    // Overflow: 8-word memory, 9 beats offered, ld_last never set
    @(negedge clk);
    o_start = 1'b1;
    @(negedge clk);
    o_start = 1'b0;
    beats = 0; we = 0; err = 0; fin = 1'b0; cyc = 0; run_seen = 1'b0; reg_seen = 1'b0;
    while (!fin && cyc < 100) begin
      o_ld_valid = (beats < 9); o_ld_last = 1'b0; o_ld_data = 32'd100 + 32'(beats);
      #1;
      if (o_ld_valid && o_ld_ready) beats++;
      if (o_mem_we) begin
        if (o_mem_addr != 3'(we) || o_mem_wdata != 32'd100 + 32'(we)) err++;
        we++;
      end
      if (o_core_run) run_seen = 1'b1;
      if (o_reg_we) reg_seen = 1'b1;
      if (o_done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    o_ld_valid = 1'b0;
    check("ovf_done_seen", fin, 1);
    check("ovf_writes", we, 8);
    check("ovf_beats_accepted", beats, 8);
    check("ovf_write_order", err, 0);
    check("ovf_flag", o_prog_ovf, 1);
    check("ovf_no_run_no_regs", {run_seen, reg_seen, o_timeout}, 0);
    @(negedge clk);
    #1;
    check("ovf_final", {o_done, o_prog_ovf, o_busy}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
